// File: rtl/fft_stream_core_pkg.sv
// Shared definitions for the streaming FFT core.
//   state_t   : frame FSM encoding (load samples, run butterflies, stream results)
//   MAX_LOG2N : largest supported log2 transform length (N_POINTS <= 256)
//   bitrev()  : reverses the low 'bits' bits of an index; upper bits return zero
package fft_stream_core_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } state_t;

  localparam int MAX_LOG2N = 8;
  localparam int BR_IW     = $clog2(MAX_LOG2N);

  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] v,
                                                  input int bits);
    logic [MAX_LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LOG2N; i++) begin
      if (i < bits) r[BR_IW'(bits - 1 - i)] = v[BR_IW'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_stream_core_twiddle_rom.sv
// Twiddle factor ROM for the FFT core.
// Entry i holds cos(2*pi*i/N) and sin(2*pi*i/N) for i = 0..N/2-1 as signed
// values with TW_W-2 fraction bits, so +1.0 is representable exactly.
// The table is built at elaboration by an integer-only Taylor evaluation in
// Q30 and rounded to nearest; the read is purely combinational.
// Ports:
//   idx      in   log2(N)-1   twiddle index
//   cos_val  out  TW_W        signed cos
//   sin_val  out  TW_W        signed sin (always >= 0 over the table range)
module fft_twiddle_rom #(
  parameter int N_POINTS = 32,
  parameter int TW_W     = 18
) (
  input  logic        [$clog2(N_POINTS)-2:0] idx,
  output logic signed [TW_W-1:0]             cos_val,
  output logic signed [TW_W-1:0]             sin_val
);

  localparam int IDX_W = $clog2(N_POINTS) - 1;
  localparam int HALF  = N_POINTS / 2;
  // Q30 -> TW_W-2 fraction bits; TW_W must stay <= 31 for this shift to be >= 1.
  localparam int SH    = 30 - (TW_W - 2);
  localparam longint PI_Q30  = 64'sd3373259426;
  localparam longint ONE_Q30 = 64'sd1073741824;

  typedef logic [HALF-1:0][2*TW_W-1:0] rom_t;

  function automatic rom_t build_rom();
    rom_t   rom;
    longint ang_idx, x, x2, term, c, s, cq, sq;
    bit     neg_cos;
    rom = '0;
    for (int i = 0; i < HALF; i++) begin
      // Fold angles above pi/2 back into [0, pi/2] so every Taylor product
      // stays well inside 64 bits: cos(pi-a) = -cos(a), sin(pi-a) = sin(a).
      if (4 * i > N_POINTS) begin
        ang_idx = longint'(HALF - i);
        neg_cos = 1'b1;
      end else begin
        ang_idx = longint'(i);
        neg_cos = 1'b0;
      end
      x  = (PI_Q30 * 2 * ang_idx) / longint'(N_POINTS);
      x2 = (x * x) >>> 30;
      term = ONE_Q30;
      c    = ONE_Q30;
      for (int n = 1; n <= 12; n++) begin
        term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
        c    = c + term;
      end
      term = x;
      s    = x;
      for (int n = 1; n <= 12; n++) begin
        term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
        s    = s + term;
      end
      if (neg_cos) c = -c;
      cq = (c + (longint'(1) <<< (SH - 1))) >>> SH;
      sq = (s + (longint'(1) <<< (SH - 1))) >>> SH;
      rom[IDX_W'(i)] = {TW_W'(cq), TW_W'(sq)};
    end
    return rom;
  endfunction

  localparam rom_t ROM = build_rom();

  assign {cos_val, sin_val} = ROM[idx];

endmodule

// File: rtl/fft_stream_core.sv
// Streaming radix-2 DIT FFT/IFFT core.
// Samples are accepted one per cycle into an in-place register file at
// bit-reversed addresses, transformed with one butterfly per cycle
// (log2(N)*N/2 cycles, no stalls), then streamed out in natural order.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   cfg_inverse  1 = IFFT (conjugate twiddles), captured on a frame's first input
//   cfg_scale    1 = arithmetic >>1 after every stage, captured with cfg_inverse
//   in_valid/in_ready/in_data     sample input, {re,im}, ready only while loading
//   out_valid/out_ready/out_data  result output, {re,im}, k = 0..N-1
//   out_last     marks result k = N-1
//   busy         high while computing or unloading
//   ovf          sticky saturation flag for the current frame
module fft_stream_core
  import fft_stream_core_pkg::*;
#(
  parameter int N_POINTS = 32,
  parameter int DATA_W   = 32,
  parameter int TW_W     = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_inverse,
  input  logic                cfg_scale,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_last,
  output logic                busy,
  output logic                ovf
);

  localparam int LOG2N = $clog2(N_POINTS);
  localparam int STG_W = (LOG2N > 2) ? $clog2(LOG2N) : 1;
  localparam int PW    = DATA_W + TW_W + 1;   // full-precision product
  localparam int SW    = DATA_W + 4;          // butterfly sum headroom

  localparam logic signed [PW-1:0] P_RND   = PW'(1) << (TW_W - 3);
  localparam logic signed [SW-1:0] SAT_MAX = {5'b00000, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {5'b11111, {(DATA_W-1){1'b0}}};

  state_t               state, state_next;
  logic [LOG2N-1:0]     cnt;
  logic [STG_W-1:0]     stage;
  logic [LOG2N-2:0]     bf_k;
  logic                 inverse_q, scale_q;
  logic [2*DATA_W-1:0]  mem [N_POINTS];

  logic                 in_fire, out_fire, last_bf;
  logic [LOG2N-1:0]     wr_addr;
  logic [LOG2N-1:0]     k_ext, j_idx, top_addr, bot_addr, tw_full;
  logic [LOG2N-2:0]     tw_idx;

  logic signed [TW_W-1:0]   tw_cos, tw_sin, w_im;
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [PW-1:0]     p_re_full, p_im_full;
  logic signed [SW-1:0]     p_re, p_im, sum_re, sum_im, dif_re, dif_im;
  logic [2*DATA_W-1:0]      a_new, b_new;
  logic                     sat_any;

  function automatic logic signed [DATA_W-1:0] clip(input logic signed [SW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  function automatic logic is_sat(input logic signed [SW-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  assign in_ready  = (state == ST_LOAD);
  assign in_fire   = in_ready && in_valid;
  assign out_valid = (state == ST_UNLOAD);
  assign out_fire  = out_valid && out_ready;
  assign out_data  = out_valid ? mem[cnt] : '0;
  assign out_last  = out_valid && (cnt == '1);
  assign busy      = (state != ST_LOAD);
  assign last_bf   = (stage == STG_W'(LOG2N - 1)) && (bf_k == '1);
  assign wr_addr   = LOG2N'(bitrev(MAX_LOG2N'(cnt), LOG2N));

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state is written with <= so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_LOAD;
    else       state <= state_next;
  end

  // NOTE: each always_comb assigns every output a default first, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_LOAD:    if (in_fire && (cnt == '1)) state_next = ST_COMPUTE;
      ST_COMPUTE: if (last_bf)                state_next = ST_UNLOAD;
      ST_UNLOAD:  if (out_fire && (cnt == '1)) state_next = ST_LOAD;
      default:    state_next = ST_LOAD;
    endcase
  end

  // ----------------------------------------------- counters, config, ovf
  // cnt wraps from N-1 to 0, so it is already zero when UNLOAD and the
  // next LOAD begin.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      stage     <= '0;
      bf_k      <= '0;
      inverse_q <= 1'b0;
      scale_q   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          if (in_fire) begin
            cnt <= cnt + 1'b1;
            if (cnt == '0) begin
              inverse_q <= cfg_inverse;
              scale_q   <= cfg_scale;
              ovf       <= 1'b0;
            end
          end
        end
        ST_COMPUTE: begin
          bf_k <= bf_k + 1'b1;
          if (bf_k == '1) stage <= last_bf ? '0 : stage + 1'b1;
          if (sat_any) ovf <= 1'b1;
        end
        ST_UNLOAD: begin
          if (out_fire) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------- sample memory
  // NOTE: mem is deliberately not reset: an aborted frame is discarded and
  // every entry is rewritten during LOAD before it is ever read.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD) begin
      if (in_fire) mem[wr_addr] <= in_data;
    end else if (state == ST_COMPUTE) begin
      mem[top_addr] <= a_new;
      mem[bot_addr] <= b_new;
    end
  end

  // ------------------------------------------------- butterfly addressing
  // j = k mod h, top = ((k>>s)<<(s+1)) + j, bot = top + h,
  // tw = j * N/2^(s+1) = j << (log2N-1-s). The doubling is done as a
  // separate <<1 so the shift amount never overflows the stage width.
  always_comb begin
    k_ext    = {1'b0, bf_k};
    j_idx    = k_ext & ((LOG2N'(1) << stage) - LOG2N'(1));
    top_addr = (((k_ext >> stage) << stage) << 1) | j_idx;
    bot_addr = top_addr | (LOG2N'(1) << stage);
    tw_full  = j_idx << (STG_W'(LOG2N - 1) - stage);
  end

  assign tw_idx = tw_full[LOG2N-2:0];

  fft_twiddle_rom #(
    .N_POINTS (N_POINTS),
    .TW_W     (TW_W)
  ) u_twiddle_rom (
    .idx     (tw_idx),
    .cos_val (tw_cos),
    .sin_val (tw_sin)
  );

  // ------------------------------------------------- butterfly datapath
  // W = cos - j*sin forward, cos + j*sin inverse. P = W*B rounded half-up
  // back to data scale; A' = A+P, B' = A-P, optional >>1, then saturate.
  always_comb begin
    {a_re, a_im} = mem[top_addr];
    {b_re, b_im} = mem[bot_addr];
    w_im = inverse_q ? tw_sin : -tw_sin;

    p_re_full = PW'(tw_cos) * PW'(b_re) - PW'(w_im) * PW'(b_im) + P_RND;
    p_im_full = PW'(tw_cos) * PW'(b_im) + PW'(w_im) * PW'(b_re) + P_RND;
    p_re      = SW'(p_re_full >>> (TW_W - 2));
    p_im      = SW'(p_im_full >>> (TW_W - 2));

    sum_re = SW'(a_re) + p_re;
    sum_im = SW'(a_im) + p_im;
    dif_re = SW'(a_re) - p_re;
    dif_im = SW'(a_im) - p_im;
    if (scale_q) begin
      sum_re = sum_re >>> 1;
      sum_im = sum_im >>> 1;
      dif_re = dif_re >>> 1;
      dif_im = dif_im >>> 1;
    end

    a_new   = {clip(sum_re), clip(sum_im)};
    b_new   = {clip(dif_re), clip(dif_im)};
    sat_any = is_sat(sum_re) || is_sat(sum_im) || is_sat(dif_re) || is_sat(dif_im);
  end

endmodule

// File: tb/tb_fft_stream_core.sv
// Self-checking bench for fft_stream_core (N=32, DATA_W=32, TW_W=18).
// A table of frames is driven through the core; for each frame the expected
// spectrum is computed with a floating-point DFT and pushed to a scoreboard,
// then popped and compared as results are handed out. A hand-written
// sequence covers reset in the middle of COMPUTE.
module tb_fft_stream_core;

  localparam int N   = 32;
  localparam int DW  = 32;
  localparam int TW  = 18;
  localparam int LAT = 81;

  logic          clk = 1'b0;
  logic          reset, cfg_inverse, cfg_scale;
  logic          in_valid, in_ready, out_valid, out_ready, out_last, busy, ovf;
  logic [2*DW-1:0] in_data, out_data;

  always #5 clk = ~clk;

  fft_stream_core #(.N_POINTS(N), .DATA_W(DW), .TW_W(TW)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_inverse (cfg_inverse),
    .cfg_scale   (cfg_scale),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .ovf         (ovf)
  );

  typedef struct {
    string  name;
    bit     inverse;
    bit     scale;
    bit     gaps;
    bit     bp;
    bit     exp_ovf;
    int     tol;
    longint xr [N];
    longint xi [N];
  } frame_t;

  typedef struct {
    longint re;
    longint im;
    bit     last;
    int     tol;
  } exp_t;

  localparam int NFR = 8;
  frame_t frames [NFR];
  exp_t   sb [$];
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp, input int tol);
    longint d;
    d = act - exp;
    n_cmp++;
    if (d < -longint'(tol) || d > longint'(tol)) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  function automatic longint rnd_clip(input real v);
    if (v > 2147483647.0)  return 64'sd2147483647;
    if (v < -2147483648.0) return -64'sd2147483648;
    return longint'($floor(v + 0.5));
  endfunction

  // Reference DFT of frame fi; pushes N expected results in natural order.
  task automatic push_expected(input int fi);
    real  re, im, ang, c, s, sgn;
    exp_t e;
    sgn = frames[fi].inverse ? 1.0 : -1.0;
    for (int k = 0; k < N; k++) begin
      re = 0.0;
      im = 0.0;
      for (int n = 0; n < N; n++) begin
        ang = 2.0 * 3.14159265358979323846 * real'(n * k) / real'(N);
        c   = $cos(ang);
        s   = sgn * $sin(ang);
        re  = re + real'(frames[fi].xr[n]) * c - real'(frames[fi].xi[n]) * s;
        im  = im + real'(frames[fi].xr[n]) * s + real'(frames[fi].xi[n]) * c;
      end
      if (frames[fi].scale) begin
        re = re / real'(N);
        im = im / real'(N);
      end
      e.re   = rnd_clip(re);
      e.im   = rnd_clip(im);
      e.last = (k == N - 1);
      e.tol  = frames[fi].tol;
      sb.push_back(e);
    end
  endtask

  task automatic run_frame(input int fi);
    frame_t f;
    exp_t   e;
    int     in_idx, out_cnt, cyc, last_in_cyc, stall;
    bit     seen_out;
    f = frames[fi];
    in_idx = 0; out_cnt = 0; cyc = 0; last_in_cyc = -1000; stall = 0; seen_out = 1'b0;
    sb.delete();
    push_expected(fi);
    while (out_cnt < N && cyc < 600) begin
      @(negedge clk);
      // Config is only honoured on the first handshake; invert it afterwards.
      cfg_inverse = (in_idx >= 1) ? !f.inverse : f.inverse;
      cfg_scale   = (in_idx >= 1) ? !f.scale   : f.scale;
      if (in_idx < N) begin
        in_valid = !(f.gaps && ($urandom_range(0, 3) == 0));
        in_data  = {f.xr[in_idx][DW-1:0], f.xi[in_idx][DW-1:0]};
      end else begin
        in_valid = 1'b1;  // must be ignored outside LOAD
        in_data  = {32'h7EADBEEF, 32'h12345678};
      end
      if (f.bp && out_cnt == 5 && out_valid && stall < 10) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      if (in_valid && in_ready) begin
        in_idx++;
        if (in_idx == N) last_in_cyc = cyc;
      end
      if (out_valid) begin
        if (!seen_out) begin
          seen_out = 1'b1;
          check($sformatf("%s latency", f.name), cyc - last_in_cyc, LAT, 0);
          check($sformatf("%s ovf", f.name), longint'(ovf), longint'(f.exp_ovf), 0);
        end
        if (sb.size() == 0) begin
          check($sformatf("%s extra output", f.name), 1, 0, 0);
        end else begin
          e = sb[0];
          check($sformatf("%s k=%0d re%s", f.name, out_cnt, out_ready ? "" : " held"),
                longint'($signed(out_data[2*DW-1:DW])), e.re, e.tol);
          check($sformatf("%s k=%0d im%s", f.name, out_cnt, out_ready ? "" : " held"),
                longint'($signed(out_data[DW-1:0])), e.im, e.tol);
          check($sformatf("%s k=%0d last%s", f.name, out_cnt, out_ready ? "" : " held"),
                longint'(out_last), longint'(e.last), 0);
          if (out_ready) begin
            void'(sb.pop_front());
            out_cnt++;
          end
        end
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (out_cnt < N) check($sformatf("%s timeout outputs", f.name), out_cnt, N, 0);
    @(negedge clk);
    check($sformatf("%s back to load", f.name), longint'(in_ready), 1, 0);
    check($sformatf("%s busy after", f.name), longint'(busy), 0, 0);
    check($sformatf("%s ovf held", f.name), longint'(ovf), longint'(f.exp_ovf), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " in_ready"},  longint'(in_ready), 1, 0);
    check({tag, " out_valid"}, longint'(out_valid), 0, 0);
    check({tag, " out_last"},  longint'(out_last), 0, 0);
    check({tag, " out_data"},  longint'(out_data), 0, 0);
    check({tag, " busy"},      longint'(busy), 0, 0);
    check({tag, " ovf"},       longint'(ovf), 0, 0);
  endtask

  initial begin
    // ---- frame table: {name, inverse, scale, gaps, bp, exp_ovf, tol, data}
    for (int fi = 0; fi < NFR; fi++) begin
      frames[fi].inverse = 0; frames[fi].scale = 0; frames[fi].gaps = 0;
      frames[fi].bp = 0; frames[fi].exp_ovf = 0; frames[fi].tol = 0;
      for (int n = 0; n < N; n++) begin
        frames[fi].xr[n] = 0;
        frames[fi].xi[n] = 0;
      end
    end
    frames[0].name = "impulse";
    frames[0].xr[0] = 1000;
    frames[1].name = "dc";
    for (int n = 0; n < N; n++) frames[1].xr[n] = 100;
    frames[2] = frames[1];
    frames[2].name = "dc_scaled";  frames[2].scale = 1;
    frames[3].name = "inv_tone";   frames[3].inverse = 1; frames[3].scale = 1;
    frames[3].tol = 2;             frames[3].xr[1] = 32768;
    frames[4] = frames[3];
    frames[4].name = "fwd_tone";   frames[4].inverse = 0;
    frames[5].name = "saturate";   frames[5].exp_ovf = 1;
    for (int n = 0; n < N; n++) frames[5].xr[n] = 64'sd2147483647;
    frames[6] = frames[1];
    frames[6].name = "dc_after_sat";
    frames[7].name = "random_bp";  frames[7].scale = 1; frames[7].gaps = 1;
    frames[7].bp = 1;              frames[7].tol = 4;
    for (int n = 0; n < N; n++) begin
      frames[7].xr[n] = longint'($urandom_range(0, 2000)) - 1000;
      frames[7].xi[n] = longint'($urandom_range(0, 2000)) - 1000;
    end

    // ---- reset
    reset = 1'b1; cfg_inverse = 1'b0; cfg_scale = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_state("after reset");

    // ---- table-driven frames
    for (int fi = 0; fi < NFR; fi++) run_frame(fi);

    // ---- reset in the middle of COMPUTE of a saturating frame
    cfg_inverse = 1'b0; cfg_scale = 1'b0;
    for (int n = 0; n < N; n++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = {32'h7FFFFFFF, 32'h0};
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (39) @(negedge clk);
    check("mid compute busy", longint'(busy), 1, 0);
    check("mid compute ovf", longint'(ovf), 1, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("after abort");
    run_frame(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
